// File: rtl/fsm_pkg.sv
// Shared encodings and pattern constants for the serial pattern transmitter and its
// matching sequence detectors.
package fsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_PAR  = 2'b10,
        ST_GAP  = 2'b11
    } tx_state_t;

    localparam int         PAT_LEN_DEF = 6;
    localparam logic [5:0] PAT_101011  = 6'b101011;

endpackage

// File: rtl/pattern_tx_if.sv
// Request/status bundle of the pattern transmitter. The requester (master) drives
// start/rpt/gap/abort; the transmitter (slave) returns s/busy/done and the state code c.
interface pattern_tx_if;
    logic       start;
    logic [3:0] rpt;
    logic [3:0] gap;
    logic       abort;
    logic       s;
    logic       busy;
    logic       done;
    logic [1:0] c;

    modport master (output start, rpt, gap, abort, input s, busy, done, c);
    modport slave  (input start, rpt, gap, abort, output s, busy, done, c);
endinterface

// File: rtl/pattern_tx_cnt.sv
// Loadable down-counter with a zero flag; used for the bit index and the gap count.
module pattern_tx_cnt #(
    parameter int W = 4
) (
    input  logic         ck,
    input  logic         rs,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge ck or negedge rs) begin
        if (!rs) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts PATTERN out MSB-first, rpt+1 frames separated by gap idle
// cycles. Define PATTERN_TX_PARITY_EN to append an even-parity bit (PAR state) to every frame.
module pattern_tx
    import fsm_pkg::*;
#(
    parameter int                 PAT_LEN  = PAT_LEN_DEF,
    parameter logic [PAT_LEN-1:0] PATTERN  = PAT_LEN'(PAT_101011),
    parameter logic               IDLE_BIT = 1'b0
) (
    input logic         ck,
    input logic         rs,
    pattern_tx_if.slave bus
);

    localparam int           BW       = $clog2(PAT_LEN);
    localparam logic [BW-1:0] BIDX_TOP = BW'(PAT_LEN - 1);
`ifdef PATTERN_TX_PARITY_EN
    localparam logic         PAR_BIT  = ^PATTERN;
`endif

    tx_state_t     state, state_nxt;
    logic          s_q, busy_q, done_q;
    logic          s_nxt, busy_nxt, done_nxt;
    logic [3:0]    frm, gap_q;
    logic          frm_load, frm_dec, frame_end;
    logic          bidx_load, bidx_en, bidx_zero;
    logic [BW-1:0] bidx;
    logic          gcnt_load, gcnt_en, gcnt_zero, gap_last;
    logic [3:0]    gcnt;

    pattern_tx_cnt #(.W(BW)) u_bidx (
        .ck       (ck),
        .rs       (rs),
        .load     (bidx_load),
        .en       (bidx_en),
        .load_val (BIDX_TOP),
        .cnt      (bidx),
        .zero     (bidx_zero)
    );

    pattern_tx_cnt #(.W(4)) u_gcnt (
        .ck       (ck),
        .rs       (rs),
        .load     (gcnt_load),
        .en       (gcnt_en),
        .load_val (gap_q),
        .cnt      (gcnt),
        .zero     (gcnt_zero)
    );

    // The gap counter holds the cycles still to idle; zero also exits so GAP can never stall.
    assign gap_last = (gcnt == 4'd1) | gcnt_zero;

    always_ff @(posedge ck or negedge rs) begin
        if (!rs) begin
            state  <= ST_IDLE;
            s_q    <= IDLE_BIT;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            frm    <= '0;
            gap_q  <= '0;
        end else begin
            state  <= state_nxt;
            s_q    <= s_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            if (frm_load) begin
                frm   <= bus.rpt;
                gap_q <= bus.gap;
            end else if (frm_dec) begin
                frm <= frm - 1'b1;
            end
        end
    end

    // s/busy/done are computed one cycle ahead so that they leave the flops with the state.
    always_comb begin
        state_nxt = state;
        s_nxt     = IDLE_BIT;
        busy_nxt  = 1'b1;
        done_nxt  = 1'b0;
        frm_load  = 1'b0;
        frm_dec   = 1'b0;
        frame_end = 1'b0;
        bidx_load = 1'b0;
        bidx_en   = 1'b0;
        gcnt_load = 1'b0;
        gcnt_en   = 1'b0;

        case (state)
            ST_IDLE: begin
                busy_nxt = 1'b0;
                if (bus.start && !bus.abort) begin
                    state_nxt = ST_SEND;
                    s_nxt     = PATTERN[PAT_LEN-1];
                    busy_nxt  = 1'b1;
                    bidx_load = 1'b1;
                    frm_load  = 1'b1;
                end
            end
            ST_SEND: begin
                if (!bidx_zero) begin
                    s_nxt   = PATTERN[bidx - 1'b1];
                    bidx_en = 1'b1;
                end else begin
`ifdef PATTERN_TX_PARITY_EN
                    state_nxt = ST_PAR;
                    s_nxt     = PAR_BIT;
`else
                    frame_end = 1'b1;
`endif
                end
            end
`ifdef PATTERN_TX_PARITY_EN
            ST_PAR: begin
                frame_end = 1'b1;
            end
`endif
            ST_GAP: begin
                if (gap_last) begin
                    state_nxt = ST_SEND;
                    s_nxt     = PATTERN[PAT_LEN-1];
                    bidx_load = 1'b1;
                end else begin
                    gcnt_en = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase

        if (frame_end) begin
            if (frm != 4'd0) begin
                frm_dec = 1'b1;
                if (gap_q == 4'd0) begin
                    state_nxt = ST_SEND;
                    s_nxt     = PATTERN[PAT_LEN-1];
                    bidx_load = 1'b1;
                end else begin
                    state_nxt = ST_GAP;
                    gcnt_load = 1'b1;
                end
            end else begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
            end
        end

        // Abort wins over everything once a transfer is under way.
        if (bus.abort && state != ST_IDLE) begin
            state_nxt = ST_IDLE;
            s_nxt     = IDLE_BIT;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b0;
            frm_dec   = 1'b0;
            bidx_load = 1'b0;
            bidx_en   = 1'b0;
            gcnt_load = 1'b0;
            gcnt_en   = 1'b0;
        end
    end

    assign bus.s    = s_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.c    = state;

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx (default build): table of frame vectors plus hand-written
// abort, reset and back-to-back sequences.
module tb_pattern_tx;

    logic ck;
    logic rs;
    int   total;
    int   bad;

    pattern_tx_if bus ();

    pattern_tx dut (
        .ck  (ck),
        .rs  (rs),
        .bus (bus)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    typedef struct {
        logic [3:0]  rpt;
        logic [3:0]  gap;
        int          len;
        logic [31:0] bits;
        int          restart_at;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int v);
        vec_t t;
        t = vecs[v];
        bus.rpt   = t.rpt;
        bus.gap   = t.gap;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check($sformatf("v%0d c_first", v), 32'(bus.c), 32'h1);
        for (int i = 0; i < t.len; i++) begin
            check($sformatf("v%0d s[%0d]", v, i), 32'(bus.s), 32'(t.bits[t.len-1-i]));
            check($sformatf("v%0d busy[%0d]", v, i), 32'(bus.busy), 32'h1);
            check($sformatf("v%0d done[%0d]", v, i), 32'(bus.done), 32'h0);
            if (i == t.restart_at) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        check($sformatf("v%0d s_end", v), 32'(bus.s), 32'h0);
        check($sformatf("v%0d busy_end", v), 32'(bus.busy), 32'h0);
        check($sformatf("v%0d done_end", v), 32'(bus.done), 32'h1);
        tick();
        check($sformatf("v%0d done_once", v), 32'(bus.done), 32'h0);
        check($sformatf("v%0d no_extra", v), 32'(bus.busy), 32'h0);
    endtask

    initial begin
        int waited;
        total     = 0;
        bad       = 0;
        rs        = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.rpt   = 4'd0;
        bus.gap   = 4'd0;

        vecs[0] = '{rpt: 4'd0, gap: 4'd0, len: 6,  bits: 32'b101011,             restart_at: -1};
        vecs[1] = '{rpt: 4'd1, gap: 4'd2, len: 14, bits: 32'b10101100101011,     restart_at: -1};
        vecs[2] = '{rpt: 4'd2, gap: 4'd0, len: 18, bits: 32'b101011101011101011, restart_at: 7};
        vecs[3] = '{rpt: 4'd1, gap: 4'd1, len: 13, bits: 32'b1010110101011,      restart_at: -1};
        vecs[4] = '{rpt: 4'd0, gap: 4'd3, len: 6,  bits: 32'b101011,             restart_at: 2};

        #1;
        check("rst_s", 32'(bus.s), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_c", 32'(bus.c), 32'h0);
        #11;
        rs = 1'b1;

        for (int v = 0; v < 5; v++) run_vec(v);

        // abort during the third bit
        bus.rpt   = 4'd0;
        bus.gap   = 4'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("abort_pre_s", 32'(bus.s), 32'h1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_s", 32'(bus.s), 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_c", 32'(bus.c), 32'h0);
        check("abort_done", 32'(bus.done), 32'h0);
        tick();
        check("abort_done_late", 32'(bus.done), 32'h0);
        run_vec(0);

        // abort in IDLE blocks a simultaneous start
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("idle_abort_busy", 32'(bus.busy), 32'h0);
        check("idle_abort_c", 32'(bus.c), 32'h0);

        // asynchronous reset in the middle of a gap
        bus.rpt   = 4'd1;
        bus.gap   = 4'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("gap_c", 32'(bus.c), 32'h3);
        check("gap_busy", 32'(bus.busy), 32'h1);
        #2;
        rs = 1'b0;
        #1;
        check("async_rst_s", 32'(bus.s), 32'h0);
        check("async_rst_busy", 32'(bus.busy), 32'h0);
        check("async_rst_c", 32'(bus.c), 32'h0);
        check("async_rst_done", 32'(bus.done), 32'h0);
        @(negedge ck);
        rs = 1'b1;
        run_vec(0);

        // back-to-back: start during the done cycle is accepted
        bus.rpt   = 4'd0;
        bus.gap   = 4'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("b2b_done", 32'(bus.done), 32'h1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'h1);
        check("b2b_s", 32'(bus.s), 32'h1);
        check("b2b_c", 32'(bus.c), 32'h1);
        check("b2b_done_clr", 32'(bus.done), 32'h0);
        waited = 0;
        while (bus.busy && waited < 20) begin
            tick();
            waited++;
        end
        check("b2b_len", 32'(waited), 32'd6);
        check("b2b_done2", 32'(bus.done), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_tx.md
# pattern_tx

Serial pattern transmitter: the driving end for the team's serial sequence detectors. On a start request it shifts a parameterised bit pattern out MSB-first, one bit per clock, on a single serial line. It can repeat the frame a programmed number of times with a programmable idle gap between frames. It sits upstream of a detector (e.g. a `101011` detector) as stimulus source and link-test generator.

## Interface
- `PAT_LEN`, 6: pattern length in bits, 2..16.
- `PATTERN`, 6'b101011: pattern, `PAT_LEN` bits; bit `PAT_LEN-1` is sent first.
- `IDLE_BIT`, 1'b0: value of `s` whenever no pattern or parity bit is being driven.
- `ck` in 1: clock; all state changes on rising edge.
- `rs` in 1: reset, asynchronous, active-low.
- `start` in 1: transmit request; sampled only in IDLE.
- `rpt` in 4: extra repetitions; `rpt = N` sends N+1 frames. Latched at accepted start.
- `gap` in 4: idle cycles between consecutive frames, 0..15. Latched at accepted start.
- `abort` in 1: synchronous stop request.
- `s` out 1: serial data, registered.
- `busy` out 1: high from the accepted start until return to IDLE, registered.
- `done` out 1: one-cycle pulse on normal completion, registered.
- `c` out 2: current state code, for debug.

## Operation
- States: IDLE=2'b00, SEND=2'b01, PAR=2'b10 (only with the macro), GAP=2'b11. Default or illegal code returns to IDLE.
- Counters:
  - `bidx`: bit index, counts down `PAT_LEN-1`..0.
  - `frm`: frames remaining, 4 bits, loaded from `rpt`.
  - `gcnt`: gap counter, 4 bits, loaded from `gap`.
- IDLE:
  - `s = IDLE_BIT`, `busy = 0`.
  - `start = 1` (and `abort = 0`) → SEND, latch `rpt`/`gap`, `bidx = PAT_LEN-1`.
- SEND:
  - `s = PATTERN[bidx]` while `bidx > 0`; decrement `bidx` each cycle.
  - After bit 0: go to PAR if the macro is defined. Otherwise:
    - if `frm > 0`: go to GAP (or straight to SEND if the latched gap = 0).
    - if `frm = 0`: go to IDLE and pulse `done`.
- GAP:
  - `s = IDLE_BIT` for exactly the latched gap count of cycles, then SEND with `bidx` reloaded and `frm` decremented.
- `start` while `busy`: ignored. It has no effect and is not queued.
- `abort = 1` in any non-IDLE state:
  - next edge → IDLE, `s = IDLE_BIT`, `busy = 0`, no `done`.
  - `abort` has priority over both `start` and completion.
  - `abort` in IDLE: no effect, and it blocks a simultaneous `start`.
- `rs` low at any time, including mid-frame:
  - immediately state IDLE, `s = IDLE_BIT`, `busy = 0`, `done = 0`, all counters 0.
  - After release, the first rising edge samples `start` normally.

## Timing
- Reset values: `s = IDLE_BIT`, `busy = 0`, `done = 0`, `c = 2'b00`.
- `start` sampled at edge k:
  - first pattern bit is on `s` and `busy = 1` after edge k.
  - bit i (0-based from MSB) is valid during cycle k+i.
- Single frame, no parity:
  - last bit during cycle k+PAT_LEN-1.
  - at edge k+PAT_LEN: `s = IDLE_BIT`, `busy = 0`, `done = 1` for that one cycle.
- Frames are spaced by PAT_LEN + gap cycles (+1 with parity), start to start.
- Back-to-back `start` is accepted: a start sampled in the same cycle `done` is high is accepted, because the state is already IDLE.

## Configuration
- `PATTERN_TX_PARITY_EN` defined:
  - after each frame, one PAR cycle drives the even-parity bit, `^PATTERN`.
  - GAP/IDLE/`done` decisions move to the end of PAR.
  - frame length becomes PAT_LEN+1.
- Undefined:
  - no PAR state, no parity logic.
  - code 2'b10 is unreachable and treated as illegal (→ IDLE).

## Structure
- Shared package `fsm_pkg` holds:
  - the 2-bit state encodings (IDLE/SEND/PAR/GAP),
  - the default pattern constant `PAT_101011`,
  - the default length 6.
- `fsm_pkg` is shared with the detector, so detector and transmitter agree on pattern constants.
- One sub-module, `pattern_tx_cnt`: a loadable down-counter (width parameter, `load`, `en`, `zero` flag), instantiated for `bidx` and `gcnt`.

## Test plan
- Defaults, `rpt=0`, `gap=0`, `start` pulsed at edge 3 → `s` = 1,0,1,0,1,1 in cycles 3..8. `s=0`, `busy=0`, `done=1` at edge 9 only.
- `rpt=1`, `gap=2` → `s` = 101011 00 101011. Single `done` after the 14th cycle. `busy` continuously high for 14 cycles.
- `rpt=2`, `gap=0` → 18 contiguous bits 101011101011101011. `start` re-pulsed mid-stream is ignored (no 4th frame).
- `abort` asserted during the 3rd bit → `s=0`, `busy=0` on the next edge. No `done`. A subsequent `start` sends a full clean frame.
- `rs` dropped asynchronously mid-GAP, between clock edges → `s`, `busy`, `c` go to reset values without waiting for `ck`. Released `rs` plus `start` → normal frame.
- `PATTERN_TX_PARITY_EN` defined, `PATTERN=6'b101010` → `s` = 1,0,1,0,1,0,1 (parity 1). `done` one cycle later than the non-parity build.
